regfile_mp: RTL and testbench

Parametrised multi-read-port general-purpose register file with a built-in clear sequencer, same-cycle write-to-read bypass and a per-register pending scoreboard. It sits between decode/issue, which reads operands and reserves destinations, and writeback, which retires results. It replaces the fixed two-port register file and writes on the rising edge only.

---
 rtl/regfile_mp_pkg.sv | 18 +
 rtl/regfile_mp_scoreboard.sv | 48 ++++
 rtl/regfile_mp.sv | 136 +++++++++++++
 tb/tb_regfile_mp.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: default geometry, the hardwired zero register index and the
// clear/run sequencer state encoding.
package regfile_mp_pkg;

  localparam int DEF_WORD_WIDTH = 32;
  localparam int DEF_REG_NUM    = 32;
  localparam int REG_ZERO       = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register pending bits: set by a reserve, cleared by a write.
// Latency: set/clear visible one cycle after the strobe; lookup is combinational.
// Backpressure: none, every strobe presented is applied.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears all bits)
//   set_en, set_addr    reserve strobe and address (caller filters register 0)
//   clr_en, clr_addr    write strobe and address (caller filters register 0)
//   rd_addr             packed per-port lookup addresses
//   pending             per-port pending bit of the addressed register
module regfile_scoreboard #(
  parameter int REG_NUM     = 32,
  parameter int REG_NUM_LOG = $clog2(REG_NUM),
  parameter int READ_PORTS  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              set_en,
  input  logic [REG_NUM_LOG-1:0]            set_addr,
  input  logic                              clr_en,
  input  logic [REG_NUM_LOG-1:0]            clr_addr,
  input  logic [READ_PORTS*REG_NUM_LOG-1:0] rd_addr,
  output logic [READ_PORTS-1:0]             pending
);

  logic [REG_NUM-1:0] pend;

  // Set wins over clear: a reserve in the same cycle as a write belongs to a
  // newer producer, so the register must stay pending. Bit 0 is never set.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (set_en && (set_addr == REG_NUM_LOG'(i))) begin
          pend[i] <= 1'b1;
        end else if (clr_en && (clr_addr == REG_NUM_LOG'(i))) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_lookup
    assign pending[p] = pend[rd_addr[p*REG_NUM_LOG +: REG_NUM_LOG]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with clear sequencer, write bypass and pending scoreboard.
// Latency: reads combinational; write visible next cycle (same cycle when bypassed); clear takes REG_NUM cycles.
// Backpressure: none; strobes are ignored only while the clear sequence runs (ready low).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset (restarts clear)
//   ready                    high once every register has been cleared
//   wr_en, wr_addr, wr_data  write strobe; also retires the pending bit
//   rsv_en, rsv_addr         reserve strobe; marks the destination pending
//   rd_addr                  packed read addresses, port p in slice p
//   rd_data, rd_pending      packed combinational read data and pending flags
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
  parameter int REG_NUM     = DEF_REG_NUM,
  parameter int REG_NUM_LOG = $clog2(REG_NUM),
  parameter int READ_PORTS  = 2,
  parameter int BYPASS      = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic                              ready,
  input  logic                              wr_en,
  input  logic [REG_NUM_LOG-1:0]            wr_addr,
  input  logic [WORD_WIDTH-1:0]             wr_data,
  input  logic                              rsv_en,
  input  logic [REG_NUM_LOG-1:0]            rsv_addr,
  input  logic [READ_PORTS*REG_NUM_LOG-1:0] rd_addr,
  output logic [READ_PORTS*WORD_WIDTH-1:0]  rd_data,
  output logic [READ_PORTS-1:0]             rd_pending
);

  localparam logic [REG_NUM_LOG-1:0] ADDR_ZERO = REG_NUM_LOG'(REG_ZERO);
  localparam logic [REG_NUM_LOG-1:0] ADDR_LAST = REG_NUM_LOG'(REG_NUM - 1);

  state_t                  state, state_nx;
  logic [REG_NUM_LOG-1:0]  clr_cnt, clr_cnt_nx;
  logic                    clr_we;
  logic                    run;
  logic                    wr_ok;
  logic                    rsv_ok;
  logic [READ_PORTS-1:0]   sb_pending;

  logic [WORD_WIDTH-1:0]   regs [REG_NUM];

  // Clear sequencer: one register per cycle, leaving CLEAR on the edge that
  // zeroes the last register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nx;
      clr_cnt <= clr_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clr_cnt_nx = clr_cnt;
    clr_we     = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt == ADDR_LAST) begin
          state_nx   = RUN;
          clr_cnt_nx = '0;
        end else begin
          clr_cnt_nx = clr_cnt + 1'b1;
        end
      end
      default: begin
        state_nx = RUN;
      end
    endcase
  end

  assign run    = (state == RUN);
  assign ready  = run;
  assign wr_ok  = run && wr_en  && (wr_addr  != ADDR_ZERO);
  assign rsv_ok = run && rsv_en && (rsv_addr != ADDR_ZERO);

  // Storage has no reset; contents are only meaningful once the clear
  // sequence has visited every entry.
  always_ff @(posedge clk) begin
    if (clr_we && !rst) begin
      regs[clr_cnt] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .REG_NUM     (REG_NUM),
    .REG_NUM_LOG (REG_NUM_LOG),
    .READ_PORTS  (READ_PORTS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (rsv_ok),
    .set_addr (rsv_addr),
    .clr_en   (wr_ok),
    .clr_addr (wr_addr),
    .rd_addr  (rd_addr),
    .pending  (sb_pending)
  );

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [REG_NUM_LOG-1:0] addr;
    logic                   hit;
    logic [WORD_WIDTH-1:0]  data;
    logic                   pend;

    assign addr = rd_addr[p*REG_NUM_LOG +: REG_NUM_LOG];
    // wr_ok already excludes register 0 and the clear phase.
    assign hit  = (BYPASS != 0) && wr_ok && (wr_addr == addr);

    always_comb begin
      data = '0;
      pend = 1'b0;
      if (run && (addr != ADDR_ZERO)) begin
        if (hit) begin
          data = wr_data;
        end else begin
          data = regs[addr];
          pend = sb_pending[p];
        end
      end
    end

    assign rd_data[p*WORD_WIDTH +: WORD_WIDTH] = data;
    assign rd_pending[p]                       = pend;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: one bypassing and one non-bypassing instance
// share the same stimulus; expectations are queued per cycle and checked by a
// separate monitor on the falling edge.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [4:0]  ra0, ra1;
  logic [9:0]  rd_addr;

  logic        ready_a, ready_b;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_pending_a, rd_pending_b;

  assign rd_addr = {ra1, ra0};

  always #5 clk = ~clk;

  regfile_mp #(.WORD_WIDTH(32), .REG_NUM(32), .READ_PORTS(2), .BYPASS(1)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready_a),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data_a),
    .rd_pending (rd_pending_a)
  );

  regfile_mp #(.WORD_WIDTH(32), .REG_NUM(32), .READ_PORTS(2), .BYPASS(0)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready_b),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data_b),
    .rd_pending (rd_pending_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expectation queue. kind = instance*8 + signal, signal:
  // 0 ready, 1 rd_data port0, 2 rd_data port1, 3 pending port0, 4 pending port1
  int          q_cyc[$];
  int          q_kind[$];
  logic [31:0] q_exp[$];
  string       q_name[$];

  int n_cmp  = 0;
  int n_fail = 0;
  bit done   = 1'b0;

  localparam int RDY = 0, D0 = 1, D1 = 2, P0 = 3, P1 = 4;
  localparam int INST_A = 0, INST_B = 8;

  function automatic logic [31:0] actual(input int k);
    case (k)
      0:  actual = {31'b0, ready_a};
      1:  actual = rd_data_a[31:0];
      2:  actual = rd_data_a[63:32];
      3:  actual = {31'b0, rd_pending_a[0]};
      4:  actual = {31'b0, rd_pending_a[1]};
      8:  actual = {31'b0, ready_b};
      9:  actual = rd_data_b[31:0];
      10: actual = rd_data_b[63:32];
      11: actual = {31'b0, rd_pending_b[0]};
      12: actual = {31'b0, rd_pending_b[1]};
      default: actual = 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic expect1(input int kind, input logic [31:0] val, input string name);
    q_cyc.push_back(cyc);
    q_kind.push_back(kind);
    q_exp.push_back(val);
    q_name.push_back(name);
  endtask

  task automatic expb(input int sig, input logic [31:0] val, input string name);
    expect1(INST_A + sig, val, name);
    expect1(INST_B + sig, val, name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  // Monitor: compares every expectation stamped with the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
        int          c, k;
        logic [31:0] e, a;
        string       nm;
        c  = q_cyc.pop_front();
        k  = q_kind.pop_front();
        e  = q_exp.pop_front();
        nm = q_name.pop_front();
        a  = actual(k);
        n_cmp++;
        if (c != cyc) begin
          n_fail++;
          $display("FAIL %s inst%0d: stale check from cycle %0d seen at cycle %0d", nm, k / 8, c, cyc);
        end else if (a !== e) begin
          n_fail++;
          $display("FAIL %s inst%0d cyc%0d: got %h, expected %h", nm, k / 8, cyc, a, e);
        end
      end
      if (done) begin
        while (q_cyc.size() > 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL %s: never checked", q_name.pop_front());
          void'(q_cyc.pop_front());
          void'(q_kind.pop_front());
          void'(q_exp.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle();
    ra0 = 5'd31;
    ra1 = 5'd1;
    repeat (3) step();
    expb(RDY, 0, "ready_in_reset");
    rst = 1'b0;

    // Clear sequence: ready rises on the 32nd edge sampling rst low.
    for (int i = 1; i <= 32; i++) begin
      step();
      expb(RDY, (i == 32) ? 32'd1 : 32'd0, "clear_ready");
      expb(D0, 0, "clear_rd0");
    end

    for (int i = 0; i < 32; i++) begin
      ra0 = 5'(i);
      ra1 = 5'(31 - i);
      expb(D0, 0, "cleared_rd0");
      expb(D1, 0, "cleared_rd1");
      expb(P0, 0, "cleared_pend0");
      step();
    end

    // Write then read back.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    step();
    idle();
    ra0 = 5'd5; ra1 = 5'd0;
    expb(D0, 32'hDEADBEEF, "wr_readback");
    expb(D1, 0, "r0_read");

    // Same-cycle bypass on port 1.
    step();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234;
    ra1 = 5'd7;
    expect1(INST_A + D1, 32'h1234, "bypass_data");
    expect1(INST_A + P1, 0, "bypass_pend");
    expect1(INST_B + D1, 0, "nobypass_old");
    expect1(INST_B + P1, 0, "nobypass_pend");
    expb(D0, 32'hDEADBEEF, "other_port_during_bypass");
    step();
    idle();
    expb(D1, 32'h1234, "after_bypass");

    // Scoreboard: reserve, then retire, then write+reserve together.
    step();
    rsv_en = 1'b1; rsv_addr = 5'd3; ra0 = 5'd3;
    expb(P0, 0, "rsv_same_cycle");
    step();
    idle();
    expb(P0, 1, "rsv_pend");
    step();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    expect1(INST_A + D0, 32'h55, "retire_bypass_data");
    expect1(INST_A + P0, 0, "retire_bypass_pend");
    expect1(INST_B + D0, 0, "retire_nobypass_data");
    expect1(INST_B + P0, 1, "retire_nobypass_pend");
    step();
    idle();
    expb(D0, 32'h55, "retired_data");
    expb(P0, 0, "retired_pend");
    step();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h66;
    rsv_en = 1'b1; rsv_addr = 5'd3;
    expect1(INST_A + D0, 32'h66, "wr_rsv_bypass_data");
    expect1(INST_A + P0, 0, "wr_rsv_bypass_pend");
    expect1(INST_B + D0, 32'h55, "wr_rsv_old_data");
    expect1(INST_B + P0, 0, "wr_rsv_old_pend");
    step();
    idle();
    expb(D0, 32'h66, "wr_rsv_data");
    expb(P0, 1, "wr_rsv_pend");

    // Register 0 protection.
    step();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0; ra0 = 5'd0;
    expb(D0, 0, "r0_same_cycle_data");
    expb(P0, 0, "r0_same_cycle_pend");
    step();
    idle();
    expb(D0, 0, "r0_data");
    expb(P0, 0, "r0_pend");

    // Reset mid-run with r4 pending.
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hAB;
    step();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd4;
    step();
    idle();
    ra0 = 5'd5; ra1 = 5'd4;
    expb(D1, 32'hAB, "r4_data");
    expb(P1, 1, "r4_pend");
    rst = 1'b1;
    step();
    rst = 1'b0;
    expb(RDY, 0, "rst_ready_drop");
    expb(P1, 0, "rst_pend_clear");
    expb(D0, 0, "rst_rd_zero");
    for (int i = 1; i <= 32; i++) begin
      if (i == 10) begin
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'hBAD;
        rsv_en = 1'b1; rsv_addr = 5'd2;
      end
      step();
      idle();
      expb(RDY, (i == 32) ? 32'd1 : 32'd0, "reclear_ready");
      expb(D0, 0, "reclear_rd0");
      expb(P1, 0, "reclear_pend1");
    end
    ra0 = 5'd1; ra1 = 5'd2;
    expb(D0, 0, "clear_drops_wr");
    expb(P1, 0, "clear_drops_rsv");
    step();
    ra0 = 5'd4; ra1 = 5'd4;
    expb(D0, 0, "r4_after_reset");
    expb(P1, 0, "r4_pend_after_reset");

    // Top register still writable after the restart.
    step();
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hA5A5A5A5;
    step();
    idle();
    ra0 = 5'd31; ra1 = 5'd31;
    expb(D0, 32'hA5A5A5A5, "r31_port0");
    expb(D1, 32'hA5A5A5A5, "r31_port1");

    step();
    step();
    done = 1'b1;
  end

endmodule
